// File: rtl/tt_alu_pin_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_alu_pkg
// Description : Shared types and constants for the ALU tile pin driver.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_alu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int c_OP_W     = 3;
  localparam int c_SETTLE_W = 4;
  localparam int c_PIN_W    = 8;
  localparam int c_FIELD_W  = 4;
  localparam int c_A_LSB    = 0;
  localparam int c_B_LSB    = 4;

  // Opcodes as the tile sees them on uio_in (zero-extended)
  localparam logic [7:0] c_OP_ADD = 8'h00;
  localparam logic [7:0] c_OP_SUB = 8'h01;
  localparam logic [7:0] c_OP_AND = 8'h02;
  localparam logic [7:0] c_OP_OR  = 8'h03;
  localparam logic [7:0] c_OP_XOR = 8'h04;
  localparam logic [7:0] c_OP_MUL = 8'h05;
  localparam logic [7:0] c_OP_CAT = 8'h06;
  localparam logic [7:0] c_OP_NOT = 8'h07;

endpackage
`default_nettype wire

// File: rtl/tt_alu_pin_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : tt_alu_pin_driver_if
// Description : Command, response and tile-pin bundle for the pin driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface tt_alu_pin_driver_if #(
  parameter int OP_W = tt_alu_pkg::c_OP_W
);
  logic            ena;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [3:0]      cmd_a;
  logic [3:0]      cmd_b;
  logic [OP_W-1:0] cmd_op;
  logic [7:0]      alu_ui_in;
  logic [7:0]      alu_uio_in;
  logic [7:0]      alu_uo_out;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [7:0]      rsp_result;
  logic            busy;
  logic [7:0]      txn_count;

  // Host plus tile environment side
  modport master (
    output ena, cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_uo_out,
    input  cmd_ready, alu_ui_in, alu_uio_in, rsp_valid, rsp_result, busy, txn_count
  );

  // Pin driver side
  modport slave (
    input  ena, cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_uo_out,
    output cmd_ready, alu_ui_in, alu_uio_in, rsp_valid, rsp_result, busy, txn_count
  );
endinterface
`default_nettype wire

// File: rtl/tt_alu_pin_driver.sv
`default_nettype none
// ============================================================================
// Module      : tt_alu_pin_driver
// Description : Drives ALU tile pins, waits a settle time, returns uo_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_alu_pin_driver
  import tt_alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int OP_W          = c_OP_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_alu_pin_driver_if.slave   bus
);

  localparam logic [c_SETTLE_W-1:0] c_SETTLE_INIT = c_SETTLE_W'(SETTLE_CYCLES - 1);

  state_t                r_state;
  logic [c_SETTLE_W-1:0] r_cnt;
  logic [c_PIN_W-1:0]    r_ui;
  logic [c_PIN_W-1:0]    r_uio;
  logic [7:0]            r_res;
  logic                  r_rv;
  logic [7:0]            r_txn;

  logic                  w_cmd_ready;
  logic                  w_accept;
  logic [c_PIN_W-1:0]    w_op_ext;

  always_comb begin
    w_op_ext             = '0;
    w_op_ext[OP_W-1:0]   = bus.cmd_op;
  end

  // Gated by rst_n so no command looks acceptable while reset is held
  assign w_cmd_ready = (r_state == IDLE) && bus.ena && rst_n;
  assign w_accept    = w_cmd_ready && bus.cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ui    <= '0;
      r_uio   <= '0;
      r_res   <= '0;
      r_rv    <= 1'b0;
      r_txn   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ui[c_A_LSB +: c_FIELD_W] <= bus.cmd_a;
            r_ui[c_B_LSB +: c_FIELD_W] <= bus.cmd_b;
            r_uio                      <= w_op_ext;
            r_cnt                      <= c_SETTLE_INIT;
            r_state                    <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_res   <= bus.alu_uo_out;
            r_rv    <= 1'b1;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rv    <= 1'b0;
            r_txn   <= r_txn + 8'd1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.alu_ui_in  = r_ui;
  assign bus.alu_uio_in = r_uio;
  assign bus.rsp_valid  = r_rv;
  assign bus.rsp_result = r_res;
  assign bus.busy       = (r_state != IDLE);
  assign bus.txn_count  = r_txn;

endmodule
`default_nettype wire

// File: tb/tb_tt_alu_pin_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_alu_pin_driver
// Description : Randomised bench for the ALU pin driver with a tile model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_alu_pin_driver;
  import tt_alu_pkg::*;

  localparam int SETTLE = 2;
  localparam int OPW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tt_alu_pin_driver_if #(.OP_W(OPW)) bus ();

  tt_alu_pin_driver #(.SETTLE_CYCLES(SETTLE), .OP_W(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tile_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [7:0] op);
    case (op)
      c_OP_ADD: return 8'(a) + 8'(b);
      c_OP_SUB: return 8'(a) - 8'(b);
      c_OP_AND: return {4'h0, a & b};
      c_OP_OR : return {4'h0, a | b};
      c_OP_XOR: return {4'h0, a ^ b};
      c_OP_MUL: return 8'(a) * 8'(b);
      c_OP_CAT: return {a, b};
      c_OP_NOT: return ~{b, a};
      default : return 8'hEE;
    endcase
  endfunction

  assign bus.alu_uo_out = tile_fn(bus.alu_ui_in[c_A_LSB +: c_FIELD_W],
                                  bus.alu_ui_in[c_B_LSB +: c_FIELD_W], bus.alu_uio_in);

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      if (n_errs <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding command, response due SETTLE edges after acceptance
  logic       m_busy = 1'b0, m_rv = 1'b0;
  int         m_age = 0, m_acc = 0, m_cyc = 0, m_acc_cyc = 0;
  logic [3:0] m_a = '0, m_b = '0;
  logic [OPW-1:0] m_op = '0;
  logic [7:0] m_ui = '0, m_uio = '0, m_res = '0, m_cnt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_rv = 1'b0; m_age = 0;
      m_ui = '0; m_uio = '0; m_res = '0; m_cnt = '0;
    end else begin
      m_cyc++;
      if (!m_busy) begin
        if (bus.ena && bus.cmd_valid) begin
          m_busy = 1'b1; m_age = 0;
          m_a = bus.cmd_a; m_b = bus.cmd_b; m_op = bus.cmd_op;
          m_ui = {bus.cmd_b, bus.cmd_a};
          m_uio = 8'(bus.cmd_op);
          m_acc++; m_acc_cyc = m_cyc;
        end
      end else if (m_rv) begin
        if (bus.rsp_ready) begin
          m_rv = 1'b0; m_busy = 1'b0; m_cnt = m_cnt + 8'd1;
        end
      end else begin
        m_age++;
        if (m_age == SETTLE) begin
          m_rv  = 1'b1;
          m_res = tile_fn(m_a, m_b, 8'(m_op));
        end
      end
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmd_ready",  32'(bus.cmd_ready),  32'(!m_busy && bus.ena && rst_n));
      chk("busy",       32'(bus.busy),       32'(m_busy));
      chk("rsp_valid",  32'(bus.rsp_valid),  32'(m_rv));
      chk("rsp_result", 32'(bus.rsp_result), 32'(m_res));
      chk("alu_ui_in",  32'(bus.alu_ui_in),  32'(m_ui));
      chk("alu_uio_in", 32'(bus.alu_uio_in), 32'(m_uio));
      chk("txn_count",  32'(bus.txn_count),  32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_cmd();
    bus.cmd_a  = 4'($urandom);
    bus.cmd_b  = 4'($urandom);
    bus.cmd_op = OPW'($urandom);
  endtask

  task automatic wait_acc(input int prev, input string name);
    for (int k = 0; k < 50; k++) begin
      tick();
      if (m_acc != prev) return;
    end
    chk({name, "_accept_timeout"}, 32'(m_acc), 32'(prev + 1));
  endtask

  task automatic wait_dut_rv(output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      seen = bus.rsp_valid;
    end
  endtask

  initial begin
    int       p;
    int       last_cyc;
    logic     seen;
    logic [7:0] exp_res;

    bus.ena = 1'b1; bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    cmp_en = 1'b1;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      tick();
      rand_cmd();
      bus.ena = 1'($urandom); bus.cmd_valid = 1'($urandom); bus.rsp_ready = 1'($urandom);
      #1;
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst_ui",        32'(bus.alu_ui_in), 32'd0);
      chk("rst_txn",       32'(bus.txn_count), 32'd0);
    end
    bus.ena = 1'b1; bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Single add: 3 + 5
    tick();
    bus.cmd_a = 4'h3; bus.cmd_b = 4'h5; bus.cmd_op = OPW'(c_OP_ADD); bus.cmd_valid = 1'b1;
    p = m_acc;
    wait_acc(p, "add");
    bus.cmd_valid = 1'b0;
    chk("add_ui",  32'(bus.alu_ui_in),  32'h53);
    chk("add_uio", 32'(bus.alu_uio_in), 32'h00);
    chk("add_rv_early", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("add_rv_early2", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("add_rv",  32'(bus.rsp_valid),  32'd1);
    chk("add_res", 32'(bus.rsp_result), 32'h08);
    bus.rsp_ready = 1'b1;
    tick();
    chk("add_txn", 32'(bus.txn_count), 32'd1);
    chk("add_rv_clr", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;

    // Backpressure with a second command queued at the source
    rand_cmd();
    exp_res = tile_fn(bus.cmd_a, bus.cmd_b, 8'(bus.cmd_op));
    bus.cmd_valid = 1'b1;
    p = m_acc;
    wait_acc(p, "bp");
    rand_cmd();
    wait_dut_rv(seen);
    chk("bp_rv_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rv_hold",  32'(bus.rsp_valid),  32'd1);
      chk("bp_res_hold", 32'(bus.rsp_result), 32'(exp_res));
      chk("bp_no_ready", 32'(bus.cmd_ready),  32'd0);
    end
    bus.rsp_ready = 1'b1;
    p = m_acc;
    wait_acc(p, "bp_next");
    bus.cmd_valid = 1'b0;
    repeat (SETTLE + 2) tick();

    // ena gating, then ena dropped mid-transaction
    bus.ena = 1'b0; bus.cmd_valid = 1'b1; rand_cmd();
    repeat (5) tick();
    chk("ena_busy",  32'(bus.busy),      32'd0);
    chk("ena_ready", 32'(bus.cmd_ready), 32'd0);
    bus.ena = 1'b1;
    p = m_acc;
    wait_acc(p, "ena");
    bus.ena = 1'b0; bus.cmd_valid = 1'b0;
    wait_dut_rv(seen);
    chk("ena_drop_rsp", 32'(seen), 32'd1);
    tick();
    bus.ena = 1'b1;
    tick();

    // Asynchronous reset while settling
    bus.cmd_a = 4'hA; bus.cmd_b = 4'($urandom); bus.cmd_op = OPW'($urandom);
    bus.cmd_valid = 1'b1;
    p = m_acc;
    wait_acc(p, "mid");
    bus.cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_ui",   32'(bus.alu_ui_in),  32'd0);
    chk("mid_uio",  32'(bus.alu_uio_in), 32'd0);
    chk("mid_rv",   32'(bus.rsp_valid),  32'd0);
    chk("mid_txn",  32'(bus.txn_count),  32'd0);
    chk("mid_busy", 32'(bus.busy),       32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      rand_cmd();
      bus.ena = 1'($urandom); bus.cmd_valid = 1'($urandom);
      #1;
      chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
      chk("mid_rst_rv",    32'(bus.rsp_valid), 32'd0);
    end
    bus.ena = 1'b1; bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Back-to-back random stream
    bus.rsp_ready = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 300; i++) begin
      rand_cmd();
      bus.cmd_valid = 1'b1;
      p = m_acc;
      wait_acc(p, "stream");
      if (i > 0) chk("stream_spacing", 32'(m_acc_cyc - last_cyc), 32'(SETTLE + 2));
      last_cyc = m_acc_cyc;
    end
    bus.cmd_valid = 1'b0;
    repeat (SETTLE + 3) tick();
    chk("stream_txn",   32'(bus.txn_count), 32'h2C);
    chk("model_txn",    32'(m_cnt),         32'h2C);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tt_alu_pin_driver.md
Name: tt_alu_pin_driver

Overview:
- Host-side master for the 4-bit ALU tile's pin interface. Accepts operation commands on a valid/ready channel and drives them onto the tile's dedicated and bidirectional input pins.
- Holds the pins stable for a programmable settle time, samples the tile's result pins, and returns the captured result on a valid/ready response channel.
- Sits between a test sequencer or host interface and the tile's ui_in/uio_in/uo_out pins. It is the initiating end of the pin protocol that the ALU tile responds to.

Parameters:
- SETTLE_CYCLES, 2: cycles the pins are held stable before the result is sampled; legal range 1..15.
- OP_W, 3: opcode width; legal range 1..8; occupies uio_in[OP_W-1:0].

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  high enables acceptance of new commands
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver can accept a command
- cmd_a  in  4  operand A
- cmd_b  in  4  operand B
- cmd_op  in  OP_W  ALU opcode
- alu_ui_in  out  8  to tile ui_in: {B, A}
- alu_uio_in  out  8  to tile uio_in: zero-extended opcode
- alu_uo_out  in  8  from tile uo_out (result)
- rsp_valid  out  1  captured result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  8  captured uo_out value
- busy  out  1  transaction in flight (state != IDLE)
- txn_count  out  8  completed-transaction counter

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE; alu_ui_in=0x00; alu_uio_in=0x00; rsp_valid=0; rsp_result=0x00; txn_count=0x00; settle counter=0; busy=0.
- cmd_ready is combinational: cmd_ready = (state==IDLE) && ena.
- States:
  - IDLE: cmd_ready per rule above. On cmd_valid&&cmd_ready, register the command and go to SETTLE.
    - alu_ui_in <= {cmd_b, cmd_a}
    - alu_uio_in <= {zeros, cmd_op}
    - counter <= SETTLE_CYCLES-1
  - SETTLE: if counter==0, rsp_result <= alu_uo_out, rsp_valid <= 1, go to RESP. Otherwise counter decrements.
  - RESP: rsp_valid=1 and rsp_result held stable. On rsp_ready: rsp_valid <= 0, txn_count <= txn_count+1 (8-bit, wraps 0xFF->0x00), go to IDLE.
- Latency: command accepted at edge E0. Pins change at E0. uo_out is sampled at edge E0+SETTLE_CYCLES. rsp_valid is high from that edge. Minimum command-to-command spacing is SETTLE_CYCLES+2 edges with rsp_ready held high.
- Pins hold their last driven value after a transaction until the next accepted command. No return-to-zero.
- ena deasserted mid-transaction: the transaction completes normally. ena only gates acceptance in IDLE.
- rsp_ready high while rsp_valid is low: ignored.
- cmd_valid while busy: not accepted (cmd_ready=0). The command must be held by the source.
- Asynchronous reset mid-transaction: everything returns to reset values immediately. The in-flight command and response are discarded and txn_count is cleared.
- alu_uio_in bits above OP_W-1 are always 0.

Decomposition:
- Shared package tt_alu_pkg:
  - state enum {IDLE, SETTLE, RESP}
  - opcode width constant and ALU opcode constants (shared with the tile and bench models)
  - pin-field position constants (A at ui_in[3:0], B at ui_in[7:4])
- No sub-module is needed. The settle counter is inline. The block is a single FSM plus datapath registers.

Test Plan:
- Reset check: hold rst_n low with random inputs -> all outputs at reset values, cmd_ready=0 during reset, cmd_ready=1 after release with ena=1.
- Single add: ALU bench model returns A+B; send a=0x3, b=0x5, op=0, SETTLE_CYCLES=2 -> alu_ui_in=0x53 and alu_uio_in=0x00 at the acceptance edge; rsp_valid rises exactly 2 edges later with rsp_result=0x08; txn_count=1 after the handshake.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_result stay stable, cmd_ready=0 throughout; release -> IDLE, next command accepted.
- Back-to-back stream: 300 commands with random a/b/op and rsp_ready=1 -> all results match the model; accept spacing = SETTLE_CYCLES+2 edges; txn_count ends at 300 mod 256 = 44 (0x2C).
- ena gating: ena=0 with cmd_valid=1 -> no acceptance; drop ena during SETTLE -> the response is still produced.
- Mid-operation reset: assert rst_n low during SETTLE -> rsp_valid stays 0, pins become 0x00 asynchronously, txn_count=0.
